// File: rtl/sim_mon_pkg.sv
// Shared definitions for the simulation result monitor.
//   mon_state_t          : monitor FSM states (IDLE -> RUN -> DONE).
//   SUITE_A_RESULT_ADDR  : result location written by SuiteA ROMs.
//   TIMEOUT_DEFAULT      : default cycle budget in RUN before a forced verdict.
package sim_mon_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mon_state_t;

    localparam logic [15:0] SUITE_A_RESULT_ADDR = 16'h01DD;
    localparam int          TIMEOUT_DEFAULT     = 1024;

endpackage : sim_mon_pkg

// File: rtl/loop_detector.sv
// Detects the end-of-program JMP-to-self loop by counting consecutive opcode
// fetches from the same PC.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   arm_i         : monitor is idle; a fetch here starts tracking (repeat=1)
//   run_i         : monitor is running; fetches update the repeat count
//   fetch_i       : opcode-fetch strobe, addr_i is the fetch PC when high
//   addr_i        : CPU address
//   halt_pulse_o  : combinational, high on the fetch that completes the loop
module loop_detector #(
    parameter int ADDR_W       = 16,
    parameter int LOOP_REPEATS = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              arm_i,
    input  logic              run_i,
    input  logic              fetch_i,
    input  logic [ADDR_W-1:0] addr_i,
    output logic              halt_pulse_o
);

    localparam int RPT_W = $clog2(LOOP_REPEATS + 1);
    localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(LOOP_REPEATS - 1);
    localparam logic [RPT_W-1:0] RPT_MAX  = RPT_W'(LOOP_REPEATS);

    logic [ADDR_W-1:0] prev_pc_q, prev_pc_d;
    logic [RPT_W-1:0]  rpt_q, rpt_d;
    logic              same_pc;

    assign same_pc = (addr_i == prev_pc_q);

    // The fetch that would lift the count to LOOP_REPEATS is the halt.
    assign halt_pulse_o = run_i && fetch_i && same_pc && (rpt_q == RPT_LAST);

    always_comb begin
        prev_pc_d = prev_pc_q;
        rpt_d     = rpt_q;
        if (fetch_i && (arm_i || run_i)) begin
            if (run_i && same_pc) begin
                if (rpt_q != RPT_MAX) begin
                    rpt_d = rpt_q + RPT_W'(1);
                end
            end else begin
                prev_pc_d = addr_i;
                rpt_d     = RPT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_pc_q <= '0;
            rpt_q     <= '0;
        end else begin
            prev_pc_q <= prev_pc_d;
            rpt_q     <= rpt_d;
        end
    end

endmodule : loop_detector

// File: rtl/sim_result_monitor.sv
// Bus-snooping end-of-test checker. Watches CPU writes to a result address,
// detects the final JMP-to-self loop, and issues a sticky pass/fail verdict.
// A cycle budget bounds runaway programs.
// Ports:
//   ph1, reset        : clock (rising edge), asynchronous active-low reset
//   addr, wdata       : CPU memory address / write data
//   memwrite, fetch   : write strobe / opcode-fetch strobe
//   check_addr        : result address to watch (static while running)
//   expected          : required final value at check_addr (static)
//   done/pass/fail    : sticky verdict; exactly one of pass/fail once done
//   timed_out         : verdict was forced by the cycle budget
//   hit, last_data    : result address written at least once / latest value
//   hit_count         : writes to check_addr (saturating)
//   cycle_count       : cycles spent in RUN (saturating)
//   dbg_state         : current monitor state (mon_state_t encoding)
module sim_result_monitor
    import sim_mon_pkg::*;
#(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 8,
    parameter int LOOP_REPEATS = 3,
    parameter int TIMEOUT      = TIMEOUT_DEFAULT,
    parameter int CNT_W        = 16
) (
    input  logic              ph1,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              memwrite,
    input  logic              fetch,
    input  logic [ADDR_W-1:0] check_addr,
    input  logic [DATA_W-1:0] expected,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic              timed_out,
    output logic              hit,
    output logic [DATA_W-1:0] last_data,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  cycle_count,
    output logic [1:0]        dbg_state
);

    localparam logic [CNT_W-1:0] CNT_ONES     = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);

    mon_state_t        state_q, state_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic              fail_q, fail_d;
    logic              timed_out_q, timed_out_d;
    logic              hit_q, hit_d;
    logic [DATA_W-1:0] last_data_q, last_data_d;
    logic [CNT_W-1:0]  hit_count_q, hit_count_d;
    logic [CNT_W-1:0]  cycle_count_q, cycle_count_d;

    logic              halt;
    logic              timeout_now;

    loop_detector #(
        .ADDR_W      (ADDR_W),
        .LOOP_REPEATS(LOOP_REPEATS)
    ) u_loop_detector (
        .clk         (ph1),
        .rst_n       (reset),
        .arm_i       (state_q == IDLE),
        .run_i       (state_q == RUN),
        .fetch_i     (fetch),
        .addr_i      (addr),
        .halt_pulse_o(halt)
    );

    always_comb begin
        state_d       = state_q;
        done_d        = done_q;
        pass_d        = pass_q;
        fail_d        = fail_q;
        timed_out_d   = timed_out_q;
        hit_d         = hit_q;
        last_data_d   = last_data_q;
        hit_count_d   = hit_count_q;
        cycle_count_d = cycle_count_q;
        timeout_now   = 1'b0;

        case (state_q)
            IDLE: begin
                if (fetch) begin
                    state_d = RUN;
                end
            end

            RUN: begin
                if (cycle_count_q != CNT_ONES) begin
                    cycle_count_d = cycle_count_q + CNT_W'(1);
                end
                // Timeout fires on the edge where the count becomes TIMEOUT-1.
                timeout_now = (cycle_count_d == TIMEOUT_LAST);

                // Capture before the verdict so a write in the halt cycle counts.
                if (memwrite && (addr == check_addr)) begin
                    last_data_d = wdata;
                    hit_d       = 1'b1;
                    if (hit_count_q != CNT_ONES) begin
                        hit_count_d = hit_count_q + CNT_W'(1);
                    end
                end

                if (halt || timeout_now) begin
                    state_d     = DONE;
                    done_d      = 1'b1;
                    // Halt takes priority over a coincident timeout.
                    timed_out_d = !halt;
                    pass_d      = halt && hit_d && (last_data_d == expected);
                    fail_d      = !pass_d;
                end
            end

            DONE: begin
                // Absorbing: everything holds until reset.
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge ph1 or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
            fail_q        <= 1'b0;
            timed_out_q   <= 1'b0;
            hit_q         <= 1'b0;
            last_data_q   <= '0;
            hit_count_q   <= '0;
            cycle_count_q <= '0;
        end else begin
            state_q       <= state_d;
            done_q        <= done_d;
            pass_q        <= pass_d;
            fail_q        <= fail_d;
            timed_out_q   <= timed_out_d;
            hit_q         <= hit_d;
            last_data_q   <= last_data_d;
            hit_count_q   <= hit_count_d;
            cycle_count_q <= cycle_count_d;
        end
    end

    assign done        = done_q;
    assign pass        = pass_q;
    assign fail        = fail_q;
    assign timed_out   = timed_out_q;
    assign hit         = hit_q;
    assign last_data   = last_data_q;
    assign hit_count   = hit_count_q;
    assign cycle_count = cycle_count_q;
    assign dbg_state   = state_q;

endmodule : sim_result_monitor

// File: tb/tb_sim_result_monitor.sv
// Bench for sim_result_monitor: directed scenarios plus randomized programs,
// every cycle compared against a history-based reference model.
module tb_sim_result_monitor;
    import sim_mon_pkg::*;

    localparam int ADDR_W  = 16;
    localparam int DATA_W  = 8;
    localparam int LR      = 3;
    localparam int TMO     = 1024;
    localparam int CNT_W   = 16;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    // ---------------- clock / reset / DUT ----------------
    logic              ph1 = 1'b0;
    logic              reset = 1'b0;
    logic [ADDR_W-1:0] addr = '0;
    logic [DATA_W-1:0] wdata = '0;
    logic              memwrite = 1'b0;
    logic              fetch = 1'b0;
    logic [ADDR_W-1:0] check_addr = SUITE_A_RESULT_ADDR;
    logic [DATA_W-1:0] expected = 8'h6E;
    logic              done, pass, fail, timed_out, hit;
    logic [DATA_W-1:0] last_data;
    logic [CNT_W-1:0]  hit_count, cycle_count;
    logic [1:0]        dbg_state;

    always #5 ph1 = ~ph1;

    sim_result_monitor #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LOOP_REPEATS(LR),
        .TIMEOUT(TMO), .CNT_W(CNT_W)
    ) dut (
        .ph1(ph1), .reset(reset), .addr(addr), .wdata(wdata),
        .memwrite(memwrite), .fetch(fetch), .check_addr(check_addr),
        .expected(expected), .done(done), .pass(pass), .fail(fail),
        .timed_out(timed_out), .hit(hit), .last_data(last_data),
        .hit_count(hit_count), .cycle_count(cycle_count), .dbg_state(dbg_state)
    );

    // ---------------- checking ----------------
    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Keeps the whole fetch-PC history and the list of captured result writes;
    // the halt is "the last LR fetches share one PC".
    logic [ADDR_W-1:0] pc_hist[$];
    logic [DATA_W-1:0] wr_hist[$];
    int m_run_cycles;
    bit m_started, m_finished, m_to, m_pass;

    function automatic void model_reset();
        pc_hist.delete();
        wr_hist.delete();
        m_run_cycles = 0;
        m_started = 0; m_finished = 0; m_to = 0; m_pass = 0;
    endfunction

    function automatic void model_step(input bit f, input logic [ADDR_W-1:0] a,
                                       input bit mw, input logic [DATA_W-1:0] wd);
        bit halt_now;
        int n;
        int cyc;
        if (m_finished) return;
        if (!m_started) begin
            if (f) begin
                m_started = 1;
                pc_hist.push_back(a);
            end
            return;
        end
        m_run_cycles++;
        cyc = (m_run_cycles > CNT_MAX) ? CNT_MAX : m_run_cycles;
        if (mw && a == check_addr) wr_hist.push_back(wd);
        halt_now = 0;
        if (f) begin
            pc_hist.push_back(a);
            n = pc_hist.size();
            if (n >= LR) begin
                halt_now = 1;
                for (int k = 1; k < LR; k++)
                    if (pc_hist[n-1-k] != pc_hist[n-1]) halt_now = 0;
            end
        end
        if (halt_now || cyc == TMO - 1) begin
            m_finished = 1;
            m_to   = !halt_now;
            m_pass = !m_to && wr_hist.size() > 0 && wr_hist[wr_hist.size()-1] == expected;
        end
    endfunction

    task automatic check_outputs(input string tag);
        int hc;
        int cc;
        logic [DATA_W-1:0] ld;
        hc = (wr_hist.size() > CNT_MAX) ? CNT_MAX : wr_hist.size();
        cc = (m_run_cycles > CNT_MAX) ? CNT_MAX : m_run_cycles;
        ld = (wr_hist.size() > 0) ? wr_hist[wr_hist.size()-1] : '0;
        check_eq({tag, ".done"},        32'(done),        32'(m_finished));
        check_eq({tag, ".pass"},        32'(pass),        32'(m_pass));
        check_eq({tag, ".fail"},        32'(fail),        32'(m_finished && !m_pass));
        check_eq({tag, ".timed_out"},   32'(timed_out),   32'(m_to));
        check_eq({tag, ".hit"},         32'(hit),         32'(wr_hist.size() > 0));
        check_eq({tag, ".last_data"},   32'(last_data),   32'(ld));
        check_eq({tag, ".hit_count"},   32'(hit_count),   32'(hc));
        check_eq({tag, ".cycle_count"}, 32'(cycle_count), 32'(cc));
    endtask

    // ---------------- driver tasks ----------------
    // Inputs change 1ns after a rising edge; outputs are sampled 1ns after it.
    task automatic step(input string tag, input bit f, input logic [ADDR_W-1:0] a,
                        input bit mw, input logic [DATA_W-1:0] wd);
        fetch = f; addr = a; memwrite = mw; wdata = wd;
        @(posedge ph1);
        model_step(f, a, mw, wd);
        #1;
        check_outputs(tag);
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 0, '0, 0, '0);
    endtask

    task automatic apply_reset(input string tag, input logic [ADDR_W-1:0] ca,
                               input logic [DATA_W-1:0] ex);
        reset = 1'b0;
        fetch = 0; memwrite = 0; addr = '0; wdata = '0;
        check_addr = ca; expected = ex;
        #1;
        model_reset();
        check_outputs(tag);
        @(posedge ph1);
        #1;
        reset = 1'b1;
    endtask

    // Scenario 1/2 shape: start fetch, one result write, then the loop.
    task automatic basic_program(input string tag, input logic [DATA_W-1:0] v);
        step(tag, 1, 16'hF000, 0, '0);
        step(tag, 0, 16'h01DD, 1, v);
        for (int i = 0; i < 3; i++) step(tag, 1, 16'hF010, 0, '0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        apply_reset("rst", SUITE_A_RESULT_ADDR, 8'h6E);
        check_eq("rst.dbg_state", 32'(dbg_state), 32'(IDLE));

        // 1: matching result
        basic_program("s1", 8'h6E);
        check_eq("s1.pass", 32'(pass), 1);
        check_eq("s1.hit_count", 32'(hit_count), 1);
        check_eq("s1.last_data", 32'(last_data), 32'h6E);
        check_eq("s1.timed_out", 32'(timed_out), 0);
        step("s1.frozen", 1, 16'h01DD, 1, 8'h55);
        idle("s1.frozen", 3);

        // 2: wrong result
        apply_reset("rst2", SUITE_A_RESULT_ADDR, 8'h6E);
        basic_program("s2", 8'h6D);
        check_eq("s2.fail", 32'(fail), 1);
        check_eq("s2.pass", 32'(pass), 0);
        check_eq("s2.last_data", 32'(last_data), 32'h6D);

        // 3: overwritten result plus a neighbouring write
        apply_reset("rst3", SUITE_A_RESULT_ADDR, 8'h6E);
        step("s3", 1, 16'hF000, 0, '0);
        step("s3", 0, 16'h01DD, 1, 8'h11);
        step("s3", 0, 16'h01DD, 1, 8'h6E);
        step("s3", 0, 16'h01DE, 1, 8'h00);
        for (int i = 0; i < 3; i++) step("s3", 1, 16'hF010, 0, '0);
        check_eq("s3.pass", 32'(pass), 1);
        check_eq("s3.hit_count", 32'(hit_count), 2);

        // 4: no result write, and writes in IDLE are ignored
        apply_reset("rst4", SUITE_A_RESULT_ADDR, 8'h6E);
        step("s4", 0, 16'h01DD, 1, 8'h6E);
        step("s4", 1, 16'hF000, 0, '0);
        for (int i = 0; i < 3; i++) step("s4", 1, 16'hF020, 0, '0);
        check_eq("s4.fail", 32'(fail), 1);
        check_eq("s4.hit", 32'(hit), 0);

        // 5: runaway program, timeout
        apply_reset("rst5", SUITE_A_RESULT_ADDR, 8'h6E);
        for (int i = 0; i < 1100; i++) step("s5", 1, 16'(16'h1000 + i), 0, '0);
        check_eq("s5.done", 32'(done), 1);
        check_eq("s5.timed_out", 32'(timed_out), 1);
        check_eq("s5.fail", 32'(fail), 1);
        check_eq("s5.cycle_count", 32'(cycle_count), TMO - 1);

        // 6: reset mid-RUN is immediate, then monitoring restarts cleanly
        apply_reset("rst6", SUITE_A_RESULT_ADDR, 8'h6E);
        step("s6", 1, 16'hF000, 0, '0);
        step("s6", 0, 16'h01DD, 1, 8'h6E);
        step("s6", 1, 16'hF010, 0, '0);
        step("s6", 1, 16'hF010, 0, '0);
        check_eq("s6.hit_before", 32'(hit), 1);
        reset = 1'b0;
        #1;
        model_reset();
        check_outputs("s6.async");
        check_eq("s6.async_hit", 32'(hit), 0);
        @(posedge ph1);
        #1;
        reset = 1'b1;
        basic_program("s6.redo", 8'h6E);
        check_eq("s6.redo_pass", 32'(pass), 1);
        apply_reset("rst6b", SUITE_A_RESULT_ADDR, 8'h6E);
        step("s6b", 1, 16'h01DD, 0, '0);
        step("s6b", 1, 16'h01DD, 0, '0);
        step("s6b", 1, 16'h01DD, 1, 8'h6E);
        check_eq("s6b.pass", 32'(pass), 1);
        check_eq("s6b.hit_count", 32'(hit_count), 1);

        // randomized programs: small PC pools halt quickly, wide pools time out
        for (int r = 0; r < 26; r++) begin
            logic [ADDR_W-1:0] ca;
            logic [ADDR_W-1:0] base;
            logic [DATA_W-1:0] ex;
            logic [ADDR_W-1:0] a;
            logic [DATA_W-1:0] wd;
            int pool_n;
            int post;
            int budget;
            ca = ($urandom_range(0, 1) == 1) ? SUITE_A_RESULT_ADDR : 16'($urandom);
            ex = 8'($urandom);
            pool_n = (r < 2) ? 256 : 4;
            base = (r < 2) ? 16'($urandom) : 16'(ca - 1);
            budget = (r < 2) ? 1100 : 400;
            apply_reset("rnd.rst", ca, ex);
            post = 0;
            for (int c = 0; c < budget && post < 4; c++) begin
                a  = 16'(base + 16'($urandom_range(0, pool_n - 1)));
                wd = ($urandom_range(0, 1) == 1) ? ex : 8'($urandom);
                step("rnd", $urandom_range(0, 2) != 0, a, $urandom_range(0, 2) == 0, wd);
                if (m_finished) post++;
            end
            check_eq("rnd.finished", 32'(done), 32'(m_finished));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        n_err++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_sim_result_monitor

// File: doc/sim_result_monitor.md
Name: sim_result_monitor

Overview:
- Bus-snooping checker that sits downstream of the CPU core's external memory bus, alongside the top-level memory.
- Watches every write to a configured result address and detects the end-of-program self-loop (JMP-to-self) that SuiteA ROMs finish with.
- Issues a sticky done/pass/fail verdict, replacing fixed-delay RAM peeking in regression benches.
- Also bounds runaway programs with a cycle timeout.

Parameters:
- ADDR_W, 16, address bus width.
- DATA_W, 8, data bus width.
- LOOP_REPEATS, 3, consecutive identical fetch addresses that count as a halt (minimum 2).
- TIMEOUT, 1024, cycles in RUN before a forced timeout verdict.
- CNT_W, 16, width of cycle and write counters.

Ports:
- ph1  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low; 0 clears all state immediately.
- addr  input  ADDR_W  CPU memory address.
- wdata  input  DATA_W  CPU write data.
- memwrite  input  1  CPU write strobe, one cycle per write.
- fetch  input  1  opcode-fetch strobe; addr is the fetch PC when high.
- check_addr  input  ADDR_W  result address to watch; static after reset release.
- expected  input  DATA_W  required final value at check_addr; static.
- done  output  1  verdict valid, sticky.
- pass  output  1  done with matching result, sticky.
- fail  output  1  done with mismatch/no write/timeout, sticky.
- timed_out  output  1  verdict forced by timeout.
- hit  output  1  at least one write to check_addr seen.
- last_data  output  DATA_W  most recent data written to check_addr.
- hit_count  output  CNT_W  writes to check_addr, saturating.
- cycle_count  output  CNT_W  cycles spent in RUN, saturating.

Behaviour:
- Reset (reset=0, async): state=IDLE; every output 0; last fetch address, repeat count and counters 0.
- States are IDLE, RUN and DONE.
- IDLE: waits for first fetch=1, then goes to RUN next edge. That fetch is recorded as prev_pc with repeat=1. Writes in IDLE are ignored.
- RUN, every cycle: cycle_count++ (saturating at all-ones).
- RUN, write capture: memwrite=1 and addr==check_addr -> last_data<=wdata, hit<=1, hit_count++ (saturating).
- RUN, fetch with addr==prev_pc -> repeat++.
- RUN, fetch with a different address -> prev_pc<=addr, repeat<=1.
- No fetch in a cycle: repeat is unchanged.
- Halt: a fetch that brings repeat to LOOP_REPEATS -> DONE at that edge.
- Timeout: cycle_count reaches TIMEOUT-1 while in RUN and no halt that cycle -> DONE with timed_out=1.
- Verdict, registered at the RUN->DONE edge:
  - pass = hit and (final last_data == expected) and !timed_out.
  - fail = !pass.
  - done=1.
  - Outputs are valid in the cycle after the halt edge and exactly one of pass/fail is 1.
- Write and halt in the same cycle: the write is captured first, and the verdict uses the new data.
- Halt and timeout in the same cycle: halt wins, timed_out=0.
- DONE: absorbing; bus activity ignored; every output frozen until reset.
- Reset mid-RUN: immediate return to IDLE with everything cleared; the next fetch restarts monitoring.
- Comparisons are exact over the full ADDR_W/DATA_W; no masking.

Decomposition:
- Shared package sim_mon_pkg holds:
  - typedef mon_state_t {IDLE, RUN, DONE}.
  - Default constants SUITE_A_RESULT_ADDR=16'h01DD and TIMEOUT_DEFAULT=1024.
- One sub-module, loop_detector, owns prev_pc/repeat and outputs halt_pulse.
- The top holds the FSM, counters and verdict.

Test Plan:
1. Fetch 0xF000, write 0x6E to 0x01DD, then fetch 0xF010 three times -> done=1, pass=1, hit_count=1, last_data=0x6E, timed_out=0.
2. Same sequence but write 0x6D -> done=1, fail=1, pass=0, last_data=0x6D.
3. Write 0x11 then 0x6E to 0x01DD, plus a write to 0x01DE, then halt -> pass=1, hit_count=2.
4. No write to 0x01DD, halt loop -> fail=1, hit=0.
5. Fetch a new address every cycle for 1100 cycles -> done and timed_out at cycle 1024, fail=1, cycle_count=1023, all frozen after.
6. Deassert reset to 0 mid-RUN after 2 repeat fetches and a hit -> all outputs 0 immediately. Release, redo scenario 1 -> pass. A same-cycle write of 0x6E plus the 3rd repeat fetch also yields pass.
